matrix_buffer: RTL and testbench
================================

MATRIX_BUFFER -- requirements
Module: matrix_buffer

Interface
REQ-001 The block SHALL have parameter ROWS, default 2, matrix row count (>=1).
REQ-002 The block SHALL have parameter COLS, default 2, matrix column count (>=1).
REQ-003 The block SHALL have parameter WIDTH, default 8, element width in bits.
REQ-004 The block SHALL have localparams RW = max(1, clog2(ROWS)), CW = max(1, clog2(COLS)) and N = ROWS*COLS.
REQ-005 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have ports wr_en  input  1, wr_row  input  RW, wr_col  input  CW and wr_data  input  WIDTH for the element write request.
REQ-008 The block SHALL have port wr_ready  output  1, high when writes are accepted.
REQ-009 The block SHALL have ports rd_en  input  1, rd_row  input  RW and rd_col  input  CW for the random read request.
REQ-010 The block SHALL have ports rd_data  output  WIDTH and rd_valid  output  1 for the read response.
REQ-011 The block SHALL have port clear  input  1, a request to zero all elements sequentially.
REQ-012 The block SHALL have ports stream_start  input  1 and stream_transpose  input  1 (0 = row-major, 1 = column-major).
REQ-013 The block SHALL have ports stream_data  output  WIDTH, stream_valid  output  1, stream_last  output  1 and stream_ready  input  1.
REQ-014 The block SHALL have port busy  output  1, high in CLEAR or STREAM.

Function
REQ-015 Storage SHALL be N words of WIDTH bits; element (r,c) SHALL be held at index r*COLS+c.
REQ-016 The FSM SHALL have states IDLE, CLEAR and STREAM; busy SHALL be high exactly when the state is not IDLE; wr_ready SHALL equal ~busy.
REQ-017 In IDLE, clear SHALL take priority over stream_start; a start request arriving with clear SHALL be dropped.
REQ-018 IDLE->CLEAR on clear: the block SHALL zero one element per cycle, indices 0..N-1, then return to IDLE; busy SHALL be high for exactly N cycles.
REQ-019 IDLE->STREAM on stream_start: the block SHALL latch stream_transpose and output all N elements, row-major (r outer) or column-major (c outer).
REQ-020 In STREAM, the first stream_valid SHALL appear one cycle after start; when valid and not ready, stream_data and stream_last SHALL hold stable.
REQ-021 In STREAM, each valid&ready beat SHALL advance the sequence; stream_last SHALL be high on element N-1 of the sequence; after that beat the FSM SHALL return to IDLE and drop stream_valid the next cycle.
REQ-022 A write SHALL occur when wr_en & wr_ready; out-of-range rows/cols (>= ROWS/COLS) SHALL be dropped silently.
REQ-023 A read request with rd_en in IDLE SHALL give rd_valid=1 and rd_data=element one cycle later; out-of-range reads SHALL return 0 with rd_valid=1.
REQ-024 rd_en SHALL be ignored while busy, leaving rd_valid=0; rd_valid SHALL be a one-cycle pulse per accepted read; rd_data SHALL hold its last value otherwise.
REQ-025 A same-cycle read and write to one address SHALL return the old (pre-write) data.
REQ-026 Writes and reads in the cycle that clear/stream_start is accepted SHALL still execute; such a write SHALL be zeroed by the CLEAR sequence and SHALL appear in the STREAM output.
REQ-027 clear, stream_start, wr_en and rd_en SHALL be ignored while busy.
REQ-028 Internal counters SHALL wrap at ROWS/COLS without overflow for non-power-of-2 sizes.

Reset
REQ-029 With rst high at a clock edge, the block SHALL zero all N elements in that single cycle, enter IDLE and clear counters.
REQ-030 With rst high, busy, rd_valid, stream_valid and stream_last SHALL be 0, and rd_data and stream_data SHALL be 0.
REQ-031 Reset SHALL abort CLEAR or STREAM immediately with no further beats, and SHALL override all other inputs in the same cycle.

Verification
REQ-032 Reset then 2x2 write of (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4, then read (1,0) -> rd_valid next cycle with rd_data=3.
REQ-033 Same matrix, stream_start with transpose=0 and stream_ready=1 -> 1,2,3,4 on consecutive cycles, stream_last with 4; with transpose=1 -> 1,3,2,4.
REQ-034 Stream with stream_ready low for 3 cycles on the second beat -> value 2 (row-major) held stable; no loss or duplication.
REQ-035 Issue clear, then wr_en to (0,0)=9 during busy -> wr_ready=0, write dropped; busy lasts 4 cycles; all reads then return 0.
REQ-036 Same-cycle write (1,1)=7 and read (1,1) holding 4 -> rd_data=4; the next read gives 7; an out-of-range read with ROWS=3 and row 3 returns 0.
REQ-037 Assert rst on the third stream beat -> stream_valid=0 next cycle, all elements read 0, and busy=0.

Source files
------------

// File: rtl/matrix_buffer.sv
// ROWS x COLS element buffer with random write/read, a sequential clear, and a
// row- or column-major streaming readout under valid/ready flow control.
module matrix_buffer #(
    parameter  int ROWS  = 2,
    parameter  int COLS  = 2,
    parameter  int WIDTH = 8,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int N     = ROWS * COLS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [RW-1:0]    wr_row,
    input  logic [CW-1:0]    wr_col,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    input  logic [RW-1:0]    rd_row,
    input  logic [CW-1:0]    rd_col,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clear,
    input  logic             stream_start,
    input  logic             stream_transpose,
    output logic [WIDTH-1:0] stream_data,
    output logic             stream_valid,
    output logic             stream_last,
    input  logic             stream_ready,
    output logic             busy
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_mem [N];
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic             r_trans;
    logic [NW-1:0]    r_clrIdx;
    logic             r_rdValid;
    logic [WIDTH-1:0] r_rdData;

    logic             w_idle;
    logic             w_wrInRange;
    logic             w_rdInRange;
    logic [NW-1:0]    w_wrIdx;
    logic [NW-1:0]    w_rdIdx;
    logic [NW-1:0]    w_strmIdx;
    logic             w_lastPos;
    logic             w_rowEnd;
    logic             w_colEnd;
    logic             w_clrEnd;

    assign w_idle      = (r_state == IDLE);
    assign w_wrInRange = ({1'b0, wr_row} < (RW+1)'(ROWS)) && ({1'b0, wr_col} < (CW+1)'(COLS));
    assign w_rdInRange = ({1'b0, rd_row} < (RW+1)'(ROWS)) && ({1'b0, rd_col} < (CW+1)'(COLS));
    assign w_wrIdx     = NW'(wr_row) * NW'(COLS) + NW'(wr_col);
    assign w_rdIdx     = NW'(rd_row) * NW'(COLS) + NW'(rd_col);
    assign w_strmIdx   = NW'(r_row) * NW'(COLS) + NW'(r_col);
    assign w_rowEnd    = (r_row == RW'(ROWS - 1));
    assign w_colEnd    = (r_col == CW'(COLS - 1));
    // Both traversal orders finish on the bottom-right element.
    assign w_lastPos   = w_rowEnd && w_colEnd;
    assign w_clrEnd    = (r_clrIdx == NW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (clear)             w_nextState = CLEAR;
                else if (stream_start) w_nextState = STREAM;
            end
            CLEAR:   if (w_clrEnd) w_nextState = IDLE;
            STREAM:  if (stream_ready && w_lastPos) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Counters stay bounded by explicit end checks so non-power-of-2 sizes never overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row    <= '0;
            r_col    <= '0;
            r_trans  <= 1'b0;
            r_clrIdx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_row    <= '0;
                    r_col    <= '0;
                    r_clrIdx <= '0;
                    if (!clear && stream_start) r_trans <= stream_transpose;
                end
                CLEAR: r_clrIdx <= w_clrEnd ? '0 : r_clrIdx + 1'b1;
                STREAM: begin
                    if (stream_ready) begin
                        if (w_lastPos) begin
                            r_row <= '0;
                            r_col <= '0;
                        end else if (!r_trans) begin
                            if (w_colEnd) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end else begin
                            if (w_rowEnd) begin
                                r_row <= '0;
                                r_col <= r_col + 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else begin
            if (wr_en && w_idle && w_wrInRange) r_mem[w_wrIdx] <= wr_data;
            if (r_state == CLEAR)               r_mem[r_clrIdx] <= '0;
        end
    end

    // Reads sample the array before this edge's write lands, giving old data on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
        end else begin
            r_rdValid <= 1'b0;
            if (rd_en && w_idle) begin
                r_rdValid <= 1'b1;
                r_rdData  <= w_rdInRange ? r_mem[w_rdIdx] : '0;
            end
        end
    end

    assign busy         = !w_idle && !rst;
    assign wr_ready     = !busy;
    assign rd_valid     = r_rdValid && !rst;
    assign rd_data      = rst ? '0 : r_rdData;
    assign stream_valid = (r_state == STREAM) && !rst;
    assign stream_last  = stream_valid && w_lastPos;
    assign stream_data  = stream_valid ? r_mem[w_strmIdx] : '0;

endmodule

// File: tb/tb_matrix_buffer.sv
// Directed bench for matrix_buffer: a 2x2 instance for the main sequences and a
// 3x2 instance for out-of-range addressing.
module tb_matrix_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, clear, stream_start, stream_transpose, stream_ready;
    logic [0:0] wr_row, wr_col, rd_row, rd_col;
    logic [7:0] wr_data;
    logic       wr_ready, rd_valid, stream_valid, stream_last, busy;
    logic [7:0] rd_data, stream_data;

    logic       bWrEn, bRdEn;
    logic [1:0] bWrRow, bRdRow;
    logic [0:0] bWrCol, bRdCol;
    logic [7:0] bWrData;
    logic       bWrReady, bRdValid, bStreamValid, bStreamLast, bBusy;
    logic [7:0] bRdData, bStreamData;

    int nChecks = 0;
    int nPass   = 0;
    int cnt;

    always #5 clk = ~clk;

    matrix_buffer #(.ROWS(2), .COLS(2), .WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .rd_valid(rd_valid),
        .clear(clear), .stream_start(stream_start), .stream_transpose(stream_transpose),
        .stream_data(stream_data), .stream_valid(stream_valid), .stream_last(stream_last),
        .stream_ready(stream_ready), .busy(busy)
    );

    matrix_buffer #(.ROWS(3), .COLS(2), .WIDTH(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .wr_en(bWrEn), .wr_row(bWrRow), .wr_col(bWrCol), .wr_data(bWrData), .wr_ready(bWrReady),
        .rd_en(bRdEn), .rd_row(bRdRow), .rd_col(bRdCol), .rd_data(bRdData), .rd_valid(bRdValid),
        .clear(1'b0), .stream_start(1'b0), .stream_transpose(1'b0),
        .stream_data(bStreamData), .stream_valid(bStreamValid), .stream_last(bStreamLast),
        .stream_ready(1'b0), .busy(bBusy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic we, input logic [0:0] wrow, input logic [0:0] wcol,
                                 input logic [7:0] wd, input logic re,
                                 input logic [0:0] rrow, input logic [0:0] rcol);
        wr_en = we; wr_row = wrow; wr_col = wcol; wr_data = wd;
        rd_en = re; rd_row = rrow; rd_col = rcol;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic readCheck(input logic [0:0] row, input logic [0:0] col, input logic [7:0] exp,
                             input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, row, col);
        checkOutput({tag, "_valid"}, rd_valid, 1);
        checkOutput({tag, "_data"}, rd_data, exp);
    endtask

    task automatic startStream(input logic trans);
        stream_transpose = trans;
        stream_ready     = 1'b1;
        stream_start     = 1'b1;
        tick();
        stream_start     = 1'b0;
        wr_en            = 1'b0;
        stream_transpose = ~trans;
    endtask

    task automatic expectStream(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                input logic [7:0] e3, input string tag);
        logic [7:0] exp [4];
        exp = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_valid%0d", tag, i), stream_valid, 1);
            checkOutput($sformatf("%s_data%0d", tag, i), stream_data, exp[i]);
            checkOutput($sformatf("%s_last%0d", tag, i), stream_last, (i == 3) ? 1 : 0);
            tick();
        end
        checkOutput({tag, "_validEnd"}, stream_valid, 0);
        checkOutput({tag, "_busyEnd"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        wr_en = 0; rd_en = 0; clear = 0; stream_start = 0; stream_transpose = 0; stream_ready = 0;
        wr_row = 0; wr_col = 0; rd_row = 0; rd_col = 0; wr_data = 0;
        bWrEn = 0; bRdEn = 0; bWrRow = 0; bWrCol = 0; bRdRow = 0; bRdCol = 0; bWrData = 0;
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rdValid", rd_valid, 0);
        checkOutput("rst_streamValid", stream_valid, 0);
        checkOutput("rst_streamLast", stream_last, 0);
        checkOutput("rst_rdData", rd_data, 0);
        checkOutput("rst_streamData", stream_data, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_wrReady", wr_ready, 1);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
        readCheck(1'b1, 1'b0, 8'd3, "rd10");
        tick();
        checkOutput("rdPulse_valid", rd_valid, 0);
        checkOutput("rdHold_data", rd_data, 3);

        startStream(1'b0);
        checkOutput("stream_busy", busy, 1);
        checkOutput("stream_wrReady", wr_ready, 0);
        expectStream(8'd1, 8'd2, 8'd3, 8'd4, "rowMajor");
        startStream(1'b1);
        expectStream(8'd1, 8'd3, 8'd2, 8'd4, "colMajor");

        startStream(1'b0);
        checkOutput("stall_data0", stream_data, 1);
        tick();
        stream_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall_valid%0d", i), stream_valid, 1);
            checkOutput($sformatf("stall_data%0d", i), stream_data, 2);
            checkOutput($sformatf("stall_last%0d", i), stream_last, 0);
            tick();
        end
        stream_ready = 1'b1;
        checkOutput("stall_release", stream_data, 2);
        tick();
        checkOutput("stall_data3", stream_data, 3);
        tick();
        checkOutput("stall_data4", stream_data, 4);
        checkOutput("stall_last4", stream_last, 1);
        tick();
        checkOutput("stall_validEnd", stream_valid, 0);

        clear = 1'b1;
        stream_start = 1'b1;
        tick();
        clear = 1'b0;
        stream_start = 1'b0;
        wr_en = 1'b1; wr_row = 0; wr_col = 0; wr_data = 8'd9;
        rd_en = 1'b1; rd_row = 1; rd_col = 1;
        cnt = 0;
        while (busy && cnt < 20) begin
            checkOutput($sformatf("clr_wrReady%0d", cnt), wr_ready, 0);
            checkOutput($sformatf("clr_noStream%0d", cnt), stream_valid, 0);
            tick();
            cnt++;
            if (cnt == 1) begin
                checkOutput("clr_rdIgnored", rd_valid, 0);
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
        end
        checkOutput("clr_busyCycles", cnt, 4);
        readCheck(1'b0, 1'b0, 8'd0, "clr00");
        readCheck(1'b0, 1'b1, 8'd0, "clr01");
        readCheck(1'b1, 1'b0, 8'd0, "clr10");
        readCheck(1'b1, 1'b1, 8'd0, "clr11");

        applyStimulus(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 1'b1);
        checkOutput("rw_valid", rd_valid, 1);
        checkOutput("rw_oldData", rd_data, 4);
        readCheck(1'b1, 1'b1, 8'd7, "rw_newData");

        bWrEn = 1'b1; bWrRow = 2'd3; bWrCol = 1'b0; bWrData = 8'hAA;
        tick();
        bWrRow = 2'd2; bWrCol = 1'b1; bWrData = 8'h55;
        tick();
        bWrEn = 1'b0;
        bRdEn = 1'b1; bRdRow = 2'd2; bRdCol = 1'b1;
        tick();
        checkOutput("oob_inRangeValid", bRdValid, 1);
        checkOutput("oob_inRangeData", bRdData, 8'h55);
        bRdRow = 2'd3; bRdCol = 1'b0;
        tick();
        bRdEn = 1'b0;
        checkOutput("oob_valid", bRdValid, 1);
        checkOutput("oob_data", bRdData, 0);

        wr_en = 1'b1; wr_row = 0; wr_col = 0; wr_data = 8'd6;
        startStream(1'b0);
        expectStream(8'd6, 8'd0, 8'd0, 8'd7, "wrOnStart");

        startStream(1'b0);
        checkOutput("abort_beat1", stream_data, 6);
        tick();
        tick();
        checkOutput("abort_beat3Valid", stream_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort_rstValid", stream_valid, 0);
        checkOutput("abort_rstBusy", busy, 0);
        tick();
        rst = 1'b0;
        checkOutput("abort_validAfter", stream_valid, 0);
        checkOutput("abort_lastAfter", stream_last, 0);
        checkOutput("abort_busyAfter", busy, 0);
        tick();
        checkOutput("abort_stillIdle", stream_valid, 0);
        readCheck(1'b0, 1'b0, 8'd0, "abort00");
        readCheck(1'b1, 1'b1, 8'd0, "abort11");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
